// File: rtl/sp_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sp_sram_pkg
// Description : Shared sizing constants and access decode for the feature-map
//               SRAM banks (single-port storage with a registered read port).
// Revision    : 1.0 - initial release
// ============================================================================
package sp_sram_pkg;

  // Word address width of one storage bank.
  localparam int SRAM_ADDR_WIDTH = 10;
  // Feature-map address: bank address plus the bank-select MSB.
  localparam int FMEM_ADDR_WIDTH = SRAM_ADDR_WIDTH + 1;
  // Word width shared by the banks and the wrapper.
  localparam int DATA_WIDTH      = 64;

  // Kind of access requested on a given cycle.
  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_e;

  // Chip enable gates everything; write enable only selects the direction.
  function automatic acc_e decode_access(input logic cen, input logic wen);
    acc_e acc;
    if (!cen) begin
      acc = ACC_IDLE;
    end else if (wen) begin
      acc = ACC_WRITE;
    end else begin
      acc = ACC_READ;
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sp_sram_if.sv
`default_nettype none
// ============================================================================
// Module      : sp_sram_if
// Description : Access bus of a single-port SRAM bank. The requester drives
//               enable, direction, address and write data; the bank returns
//               registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface sp_sram_if #(
  parameter int ADDR_WIDTH = sp_sram_pkg::SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = sp_sram_pkg::DATA_WIDTH
);

  logic                  cen;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] ad;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] rd;

  // Requester side.
  modport master (
    output cen,
    output wen,
    output ad,
    output wd,
    input  rd
  );

  // Storage side.
  modport slave (
    input  cen,
    input  wen,
    input  ad,
    input  wd,
    output rd
  );

endinterface
`default_nettype wire

// File: rtl/sp_sram.sv
`default_nettype none
// ============================================================================
// Module      : sp_sram
// Description : Single-port synchronous SRAM bank. One read or one write per
//               cycle, read data registered with one cycle of latency.
//               Contents are not initialised and survive reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_sram #(
  parameter int ADDR_WIDTH = sp_sram_pkg::SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = sp_sram_pkg::DATA_WIDTH
) (
  input  wire        clk,
  input  wire        rst,
  sp_sram_if.slave   bus
);

  import sp_sram_pkg::*;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Storage array; deliberately has no reset so contents persist across rst.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] rd_d;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  write_en;
  acc_e                  access;

  // Decode the cycle's access; reset suppresses both the write and the read.
  always_comb begin
    access   = decode_access(bus.cen, bus.wen);
    write_en = 1'b0;
    rd_d     = rd_q;
    if (!rst) begin
      case (access)
        ACC_WRITE: write_en = 1'b1;
        ACC_READ:  rd_d     = mem_q[bus.ad];
        default:   ;
      endcase
    end
  end

  // Array write port; a write leaves the read register untouched (no write-through).
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem_q[bus.ad] <= bus.wd;
    end
  end

  // Read data register, cleared by reset and otherwise holding between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign bus.rd = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_sp_sram.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_sram
// Description : Self-checking bench for sp_sram. Directed vectors hold the
//               inputs and the rd value expected after the edge; expected
//               values are queued when a cycle is driven and popped when the
//               DUT output is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_sram;

  localparam int AW = 10;
  localparam int DW = 64;

  typedef struct {
    logic          rst;
    logic          cen;
    logic          wen;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_rd;
  } vec_t;

  logic clk;
  logic rst;

  sp_sram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sp_sram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_q [$];
  string         tag_q [$];
  vec_t          vecs  [$];

  // Drive one cycle, queue its expectation, then sample rd just after the edge.
  task automatic apply(input string tag, input logic r, input logic c, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] e);
    logic [DW-1:0] exp_v;
    string         t;
    @(negedge clk);
    rst     = r;
    bus.cen = c;
    bus.wen = w;
    bus.ad  = a;
    bus.wd  = d;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    n_cmp++;
    if (bus.rd !== exp_v) begin
      n_fail++;
      $display("FAIL %s: rd got %h, expected %h", t, bus.rd, exp_v);
    end
  endtask

  task automatic add(input logic r, input logic c, input logic w,
                     input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW-1:0] e);
    vec_t v;
    v.rst = r; v.cen = c; v.wen = w; v.ad = a; v.wd = d; v.exp_rd = e;
    vecs.push_back(v);
  endtask

  localparam logic [DW-1:0] ONES = {DW{1'b1}};
  localparam logic [DW-1:0] BEEF = 64'hDEADBEEF_01234567;

  initial begin
    logic [DW-1:0] last;

    rst     = 1'b1;
    bus.cen = 1'b0;
    bus.wen = 1'b0;
    bus.ad  = '0;
    bus.wd  = '0;

    //   rst   cen   wen   ad        wd            expected rd after edge
    add(1'b1, 1'b0, 1'b0, 10'd0,    64'd0,        64'd0);   // reset state
    add(1'b0, 1'b1, 1'b1, 10'd5,    BEEF,         64'd0);   // write: rd unchanged
    add(1'b0, 1'b1, 1'b0, 10'd5,    64'd0,        BEEF);    // write then read
    add(1'b0, 1'b1, 1'b1, 10'd0,    64'd1,        BEEF);    // low extreme
    add(1'b0, 1'b1, 1'b1, 10'd1023, ONES,         BEEF);    // high extreme
    add(1'b0, 1'b1, 1'b0, 10'd0,    64'd0,        64'd1);
    add(1'b0, 1'b1, 1'b0, 10'd1023, 64'd0,        ONES);
    add(1'b0, 1'b1, 1'b1, 10'd7,    64'hAA,       ONES);    // enable gating
    add(1'b0, 1'b0, 1'b1, 10'd7,    64'h55,       ONES);
    add(1'b0, 1'b0, 1'b1, 10'd7,    64'h55,       ONES);
    add(1'b0, 1'b0, 1'b1, 10'd7,    64'h55,       ONES);
    add(1'b0, 1'b1, 1'b0, 10'd7,    64'd0,        64'hAA);
    add(1'b0, 1'b1, 1'b1, 10'd3,    64'h11,       64'hAA);  // read-then-write
    add(1'b0, 1'b1, 1'b0, 10'd3,    64'd0,        64'h11);
    add(1'b0, 1'b1, 1'b1, 10'd3,    64'h22,       64'h11);
    add(1'b0, 1'b1, 1'b0, 10'd3,    64'd0,        64'h22);
    add(1'b0, 1'b1, 1'b1, 10'd9,    64'h1234,     64'h22);  // reset behaviour
    add(1'b0, 1'b1, 1'b0, 10'd9,    64'd0,        64'h1234);
    add(1'b1, 1'b1, 1'b1, 10'd3,    64'h99,       64'd0);
    add(1'b0, 1'b0, 1'b0, 10'd3,    64'd0,        64'd0);
    add(1'b0, 1'b1, 1'b0, 10'd3,    64'd0,        64'h22);
    add(1'b0, 1'b1, 1'b0, 10'd9,    64'd0,        64'h1234);
    add(1'b1, 1'b0, 1'b0, 10'd0,    64'd0,        64'd0);   // rst falls, then
    add(1'b0, 1'b1, 1'b0, 10'd1023, 64'd0,        ONES);    // first access normal

    foreach (vecs[i]) begin
      apply($sformatf("vec[%0d]", i), vecs[i].rst, vecs[i].cen, vecs[i].wen,
            vecs[i].ad, vecs[i].wd, vecs[i].exp_rd);
    end

    // Streaming: 16 back-to-back writes then 16 back-to-back reads.
    last = ONES;
    for (int i = 0; i < 16; i++) begin
      logic [AW-1:0] a;
      a = AW'(32 + i);
      apply($sformatf("stream_wr[%0d]", i), 1'b0, 1'b1, 1'b1, a,
            DW'(a) * 64'h0101, last);
    end
    for (int i = 0; i < 16; i++) begin
      logic [AW-1:0] a;
      a = AW'(32 + i);
      apply($sformatf("stream_rd[%0d]", i), 1'b0, 1'b1, 1'b0, a, 64'd0,
            DW'(a) * 64'h0101);
    end

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sp_sram.md
Name: sp_sram

Overview:
- Single-port synchronous SRAM model, one read or one write per cycle, with a registered read port.
- Used as the storage bank inside the feature-map memory wrapper. Two instances form a banked pair, selected by the address MSB.
- Behavioural, synthesisable RTL with a register array. It has no hard-macro dependency.

Parameters:
- ADDR_WIDTH, default 10 (SRAM_ADDR_WIDTH): word address width. Depth = 2**ADDR_WIDTH.
- DATA_WIDTH, default 64: word width in bits.

Ports:
- clk  input  1  Sole clock. All activity is on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- cen  input  1  Chip enable, active-high. No access occurs when it is low.
- ad  input  ADDR_WIDTH  Word address for the read or write.
- wd  input  DATA_WIDTH  Write data.
- wen  input  1  Write enable, active-high. Only effective when cen=1.
- rd  output  DATA_WIDTH  Registered read data.

Behaviour:
- Interface fixed for this block: one clock (clk); reset rst is synchronous and active-high.
- All state changes occur on posedge clk. There is no combinational path from inputs to rd.
- Reset (rst=1 at an edge):
  - rd <= 0.
  - No array write occurs that cycle, whatever cen/wen are. Reset has priority.
  - Array contents are not cleared and are retained across reset.
- Write (rst=0, cen=1, wen=1): mem[ad] <= wd. rd holds its previous value; there is no write-through.
- Read (rst=0, cen=1, wen=0): rd <= mem[ad]. Latency is 1 cycle: the address at edge N gives data on rd after edge N.
- Idle (rst=0, cen=0): no access. rd holds its last value. wen and ad are don't-care, and wen=1 with cen=0 must not modify the array.
- Back-to-back accesses are allowed every cycle, with no bubbles required:
  - Write then read of the same address on the next cycle returns the new data.
  - Read then write of the same address: the read returns the old data.
- Power-up contents are undefined and are not initialised. X in simulation is acceptable; the bench writes before reading.
- Full address range 0 .. 2**ADDR_WIDTH-1 is valid. There is no wrap or out-of-range case, since every ad value maps to a word.
- Width rules:
  - wd is stored exactly, with no byte masking; the whole word is written.
  - rd is DATA_WIDTH bits, zero on reset.
- Reset deasserted mid-operation: the first access on the edge after rst falls proceeds normally.

Decomposition:
- Shared package/define file (hwpe_define): SRAM_ADDR_WIDTH (10), FMEM_ADDR_WIDTH (SRAM_ADDR_WIDTH+1, with the bank-select MSB), DATA_WIDTH (64).
- Single flat module. No sub-module is warranted; the array plus the rd register is the whole block.

Test Plan:
- Write then read:
  - Reset, then write 0xDEADBEEF_01234567 to addr 5 (cen=1, wen=1).
  - Next cycle read addr 5 (cen=1, wen=0).
  - Required: rd = 0xDEADBEEF_01234567 one cycle after the read edge; rd unchanged during the write cycle.
- Address extremes:
  - Write 0x1 to addr 0 and 0xFFFF_FFFF_FFFF_FFFF to addr 1023, then read both back-to-back.
  - Required: rd shows 0x1, then all-ones on consecutive cycles with no cross-corruption.
- Enable gating:
  - Write 0xAA to addr 7.
  - Then drive cen=0, wen=1, wd=0x55, ad=7 for 3 cycles; then read addr 7.
  - Required: rd holds its prior value while cen=0; the readback is 0xAA.
- Read-then-write same address:
  - Holding 0x11 at addr 3, read addr 3, then write 0x22 to addr 3, then read addr 3.
  - Required: rd = 0x11, then still 0x11 (held during the write), then 0x22.
- Reset:
  - With rd = 0x1234 from a read, assert rst for 1 cycle with cen=1, wen=1, ad=3, wd=0x99.
  - Required: rd = 0 after the reset edge; a later read of addr 3 returns the pre-reset content, not 0x99.
- Streaming:
  - Write 16 consecutive addresses with data = addr*0x0101, then read them in 16 consecutive cycles.
  - Required: each rd matches with exactly 1-cycle latency.
